// File: rtl/fifo_pkg.sv
// Shared defaults, lane-count/keep types and the keep-mask helper for the FIFO read packer.
package fifo_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_RATIO  = 2;
  localparam int unsigned MAX_RATIO  = 8;

  // Sized for the largest legal RATIO so one type serves every instance.
  typedef logic [$clog2(MAX_RATIO+1)-1:0] lane_cnt_t;
  typedef logic [MAX_RATIO-1:0]           keep_t;

  function automatic keep_t keep_from_cnt(input lane_cnt_t cnt);
    logic [MAX_RATIO:0] one_hot;
    one_hot = (MAX_RATIO+1)'(1) << cnt;
    return keep_t'(one_hot - (MAX_RATIO+1)'(1));
  endfunction
endpackage

// File: rtl/fifo_out_slot.sv
// One-entry valid/ready output register: a load wins over an accept in the same cycle.
// free_o is high when a load this cycle cannot overwrite an unaccepted beat.
module fifo_out_slot
  import fifo_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned K = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] dat_i,
  input  logic [K-1:0] keep_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic [K-1:0] keep_o,
  output logic         free_o
);
  logic         vld_q;
  logic [W-1:0] dat_q;
  logic [K-1:0] keep_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      keep_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      dat_q  <= dat_i;
      keep_q <= keep_i;
    end else if (vld_q && rdy_i) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign dat_o  = dat_q;
  assign keep_o = keep_q;
  assign free_o = !vld_q || rdy_i;
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops async_fifo words (1-cycle read latency) and packs RATIO of them per valid/ready beat.
// A full beat blocked by downstream parks in the accumulator and stops further pops.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RATIO  = DEF_RATIO,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    rd_clk,
  input  logic                    res,
  input  logic                    empty,
  input  logic                    underflow,
  input  logic [DATA_W-1:0]       rdata,
  output logic                    rd_en,
  input  logic                    flush,
  output logic [DATA_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]        out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        pop_count,
  output logic                    err_underflow
);
  localparam lane_cnt_t RATIO_C = lane_cnt_t'(RATIO);

  logic                    run_q;
  logic                    inflight_q;
  logic                    flush_pend_q, flush_pend_d;
  lane_cnt_t               acc_cnt_q, acc_cnt_d, fill_cnt;
  logic [DATA_W-1:0]       lane_q [RATIO];
  logic [CNT_W-1:0]        pop_cnt_q;
  logic                    err_q;
  logic [DATA_W*RATIO-1:0] beat_dat;
  logic [RATIO-1:0]        beat_keep;
  logic                    slot_free, full_now, flush_exec, load;

  // run_q keeps rd_en low until the first edge after reset release.
  assign rd_en      = run_q && !empty && !flush_pend_q &&
                      ((acc_cnt_q + lane_cnt_t'(inflight_q)) < RATIO_C);
  assign fill_cnt   = acc_cnt_q + lane_cnt_t'(inflight_q);
  assign full_now   = (fill_cnt == RATIO_C);
  assign flush_exec = flush_pend_q && !inflight_q && (acc_cnt_q != '0);
  assign load       = slot_free && (full_now || flush_exec);
  assign acc_cnt_d  = load ? '0 : fill_cnt;
  assign beat_keep  = RATIO'(keep_from_cnt(fill_cnt));

  // Lanes at or beyond the fill point are zeroed so no stale word leaks out.
  always_comb begin
    beat_dat = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_cnt_t'(i) < acc_cnt_q)
        beat_dat[i*DATA_W +: DATA_W] = lane_q[i];
      else if (inflight_q && (lane_cnt_t'(i) == acc_cnt_q))
        beat_dat[i*DATA_W +: DATA_W] = rdata;
    end
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_pend_q && !inflight_q && ((acc_cnt_q == '0) || load))
      flush_pend_d = 1'b0;
    if (flush)
      flush_pend_d = 1'b1;
  end

  always_ff @(posedge rd_clk or negedge res) begin
    if (!res) begin
      run_q        <= 1'b0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      acc_cnt_q    <= '0;
      pop_cnt_q    <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < RATIO; i++) lane_q[i] <= '0;
    end else begin
      run_q        <= 1'b1;
      inflight_q   <= rd_en;
      flush_pend_q <= flush_pend_d;
      acc_cnt_q    <= acc_cnt_d;
      err_q        <= err_q | underflow;
      if (rd_en) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
      for (int i = 0; i < RATIO; i++)
        if (inflight_q && (lane_cnt_t'(i) == acc_cnt_q)) lane_q[i] <= rdata;
    end
  end

  assign pop_count     = pop_cnt_q;
  assign err_underflow = err_q;

  fifo_out_slot #(
    .W (DATA_W*RATIO),
    .K (RATIO)
  ) u_out_slot (
    .clk_i   (rd_clk),
    .rst_n_i (res),
    .load_i  (load),
    .dat_i   (beat_dat),
    .keep_i  (beat_keep),
    .rdy_i   (out_ready),
    .vld_o   (out_valid),
    .dat_o   (out_data),
    .keep_o  (out_keep),
    .free_o  (slot_free)
  );
endmodule
